// File: rtl/vp_pkg.sv
// Shared definitions for the vector issue controller: legal opcodes,
// FSM state encoding, the queued-entry layout and the opcode legality check.
package vp_pkg;

    localparam logic [6:0] VADD = 7'h00;
    localparam logic [6:0] VSUB = 7'h01;
    localparam logic [6:0] VMUL = 7'h02;
    localparam logic [6:0] VLE  = 7'h40;
    localparam logic [6:0] VSE  = 7'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } vp_state_e;

    typedef struct packed {
        logic [6:0]  funct;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic [4:0]  vr;
        logic [31:0] vl;
    } vp_entry_t;

    function automatic logic is_legal_funct(input logic [6:0] funct);
        case (funct)
            VADD, VSUB, VMUL, VLE, VSE: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vec_issue_fifo.sv
// Synchronous instruction FIFO. The head entry is read combinationally so the
// controller can capture it on the same edge it decides to issue.
// DEPTH must be a power of two so the pointers wrap naturally.
module vec_issue_fifo
    import vp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  vp_entry_t                i_data,
    input  logic                     i_pop,
    output vp_entry_t                o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    vp_entry_t         r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vec_issue_ctrl.sv
// Vector issue controller: queues instructions from the core, tracks the
// architectural vector length and sequences the vector unit one op at a time
// (start pulse, wait for done, watchdog abort).
module vec_issue_ctrl
    import vp_pkg::*;
#(
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic [6:0]                    instr_funct,
    input  logic [4:0]                    instr_vs1,
    input  logic [4:0]                    instr_vs2,
    input  logic [4:0]                    instr_vr,
    input  logic                          cfg_valid,
    input  logic [31:0]                   cfg_vl,
    output logic                          vp_enable,
    output logic                          vp_start_op,
    output logic [6:0]                    vp_funct,
    output logic [4:0]                    vp_vs1,
    output logic [4:0]                    vp_vs2,
    output logic [4:0]                    vp_vr,
    output logic [31:0]                   vp_vl,
    input  logic                          vp_op_done,
    output logic                          busy,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
    output logic [15:0]                   retired_count,
    output logic                          illegal_err,
    output logic                          timeout_err,
    input  logic                          clear_err
);

    localparam int CW  = $clog2(QUEUE_DEPTH) + 1;
    localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;

    vp_state_e         r_state;
    vp_state_e         w_next;
    vp_entry_t         w_new;
    vp_entry_t         w_head;
    vp_entry_t         r_vp;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_accept;
    logic              w_legal;
    logic              w_push;
    logic              w_pop;
    logic              w_retire;
    logic              w_timeout;
    logic [31:0]       r_vl;
    logic [WDW-1:0]    r_wdog;
    logic              r_start;
    logic              r_enable;
    logic [15:0]       r_retired;
    logic              r_illegal;
    logic              r_timeout;

    assign w_accept = instr_valid && instr_ready;
    assign w_legal  = is_legal_funct(instr_funct);
    assign w_push   = w_accept && w_legal;
    // A config write in the same cycle as a push is what the new entry sees.
    assign w_new    = '{funct: instr_funct, vs1: instr_vs1, vs2: instr_vs2,
                        vr: instr_vr, vl: (cfg_valid ? cfg_vl : r_vl)};

    vec_issue_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_new),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign instr_ready   = !w_full;
    assign busy          = !w_empty || (r_state != IDLE);
    assign queue_count   = w_count;
    assign vp_enable     = r_enable;
    assign vp_start_op   = r_start;
    assign vp_funct      = r_vp.funct;
    assign vp_vs1        = r_vp.vs1;
    assign vp_vs2        = r_vp.vs2;
    assign vp_vr         = r_vp.vr;
    assign vp_vl         = r_vp.vl;
    assign retired_count = r_retired;
    assign illegal_err   = r_illegal;
    assign timeout_err   = r_timeout;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; done takes priority over a watchdog expiry in the same cycle.
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        w_retire  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE:  if (!w_empty) w_next = ISSUE;
            ISSUE: w_next = WAIT;
            WAIT: begin
                if (vp_op_done) begin
                    w_pop    = 1'b1;
                    w_retire = 1'b1;
                    w_next   = IDLE;
                end else if (r_wdog == WDW'(TIMEOUT_CYCLES - 1)) begin
                    w_pop     = 1'b1;
                    w_timeout = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Watchdog counts cycles spent in WAIT, restarted by every issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_wdog <= '0;
        else if (r_state == ISSUE)           r_wdog <= '0;
        else if (r_state == WAIT && !w_pop)  r_wdog <= r_wdog + 1'b1;
    end

    // Architectural vector length, loaded unclamped by config writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_vl <= '0;
        else if (cfg_valid) r_vl <= cfg_vl;
    end

    // Unit-facing outputs, registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable <= 1'b0;
            r_start  <= 1'b0;
            r_vp     <= '0;
        end else begin
            r_enable <= 1'b1;
            r_start  <= (w_next == ISSUE);
            r_vp     <= (w_next == IDLE) ? '0 : w_head;
        end
    end

    // Retire counter and sticky error flags; a set event beats clear_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_retire) r_retired <= r_retired + 1'b1;
            if (w_accept && !w_legal) r_illegal <= 1'b1;
            else if (clear_err)       r_illegal <= 1'b0;
            if (w_timeout)            r_timeout <= 1'b1;
            else if (clear_err)       r_timeout <= 1'b0;
        end
    end

endmodule
